// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle fetch/exec/memory/writeback sequencer for the NPC core
module exec_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_q,
    input  logic        dec_wen,
    input  logic        dec_mem,
    input  logic        dec_mem_wen,
    input  logic        dec_csr_wen,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    output logic        rf_we,
    output logic        csr_we,
    output logic        pc_we,
    output logic [31:0] instret,
    output logic        halt,
    output logic        err,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_IWAIT = 4'd2,
        S_EXEC  = 4'd3,
        S_MEM   = 4'd4,
        S_DWAIT = 4'd5,
        S_WB    = 4'd6,
        S_HALT  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    localparam logic [31:0]     EBREAK  = 32'h00100073;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic [31:0]     r_inst_q;
    logic [31:0]     r_instret;
    logic            r_imem_req;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic            r_rf_we;
    logic            r_csr_we;
    logic            r_pc_we;
    logic            r_halt;
    logic            r_err;

    state_t          w_next;
    logic [TO_W-1:0] w_cnt_next;
    logic            w_wait;
    logic            w_exit;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        w_wait     = 1'b0;
        w_exit     = 1'b0;
        case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: begin
                w_wait = 1'b1;
                w_exit = imem_gnt;
                if (imem_gnt) w_next = S_IWAIT;
            end
            S_IWAIT: begin
                w_wait = 1'b1;
                w_exit = imem_rvalid;
                if (imem_rvalid) w_next = S_EXEC;
            end
            S_EXEC: begin
                if (r_inst_q == EBREAK) w_next = S_HALT;
                else if (dec_mem)       w_next = S_MEM;
                else                    w_next = S_WB;
            end
            S_MEM: begin
                w_wait = 1'b1;
                w_exit = dmem_gnt;
                if (dmem_gnt) w_next = S_DWAIT;
            end
            S_DWAIT: begin
                w_wait = 1'b1;
                w_exit = dmem_rvalid;
                if (dmem_rvalid) w_next = S_WB;
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
        // A handshake in the final allowed cycle still exits rather than timing out.
        if (w_wait && !w_exit) begin
            if (r_cnt == TO_LAST) w_next = S_ERR;
            else                  w_cnt_next = r_cnt + 1'b1;
        end
    end

    // Outputs are registered from the next state so they align with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_inst_q   <= '0;
            r_instret  <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_we    <= 1'b0;
            r_csr_we   <= 1'b0;
            r_pc_we    <= 1'b0;
            r_halt     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_imem_req <= (w_next == S_FETCH);
            r_dmem_req <= (w_next == S_MEM);
            r_dmem_we  <= (w_next == S_MEM) && dec_mem_wen;
            r_rf_we    <= (w_next == S_WB) && dec_wen && !dec_mem_wen;
            r_csr_we   <= (w_next == S_WB) && dec_csr_wen;
            r_pc_we    <= (w_next == S_WB);
            r_halt     <= (w_next == S_HALT);
            r_err      <= (w_next == S_ERR);
            if (r_state == S_IWAIT && imem_rvalid) r_inst_q <= imem_rdata;
            if (r_state == S_WB) r_instret <= r_instret + 32'd1;
        end
    end

    assign imem_req = r_imem_req;
    assign inst_q   = r_inst_q;
    assign dmem_req = r_dmem_req;
    assign dmem_we  = r_dmem_we;
    assign rf_we    = r_rf_we;
    assign csr_we   = r_csr_we;
    assign pc_we    = r_pc_we;
    assign instret  = r_instret;
    assign halt     = r_halt;
    assign err      = r_err;
    assign state    = r_state;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - self-checking bench for exec_sequencer
module tb_exec_sequencer;

    localparam int TO = 8;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_IWAIT = 2, ST_EXEC = 3, ST_MEM = 4,
                   ST_DWAIT = 5, ST_WB = 6, ST_HALT = 7, ST_ERR = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata, inst_q;
    logic        dec_wen, dec_mem, dec_mem_wen, dec_csr_wen;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic        rf_we, csr_we, pc_we;
    logic [31:0] instret;
    logic        halt, err;
    logic [3:0]  state;

    exec_sequencer #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .inst_q(inst_q),
        .dec_wen(dec_wen), .dec_mem(dec_mem), .dec_mem_wen(dec_mem_wen), .dec_csr_wen(dec_csr_wen),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .rf_we(rf_we), .csr_we(csr_we), .pc_we(pc_we), .instret(instret),
        .halt(halt), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        wen, mem, mwen, csr;
        int          g, r, dg, dr;
        int          exp_cycles;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_instret, m_inst_q;
    logic        cur_wen, cur_mwen, cur_csr;
    int          sq[$];
    bit          sf[$];
    vec_t        tbl[5];

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [75:0] actv();
        return {inst_q, instret, state, imem_req, dmem_req, dmem_we, rf_we, csr_we, pc_we, halt, err};
    endfunction

    function automatic logic [75:0] expv(input int st);
        logic [3:0] s;
        s = st[3:0];
        return {m_inst_q, m_instret, s, st == ST_FETCH, st == ST_MEM, st == ST_MEM && cur_mwen,
                st == ST_WB && cur_wen && !cur_mwen, st == ST_WB && cur_csr, st == ST_WB,
                st == ST_HALT, st == ST_ERR};
    endfunction

    // Reference schedule: each wait of d idle cycles lasts d+1 cycles, or times out after TO.
    task automatic push_wait(input int st, input int d, output bit term);
        term = 1'b0;
        if (d >= TO) begin
            for (int k = 0; k < TO; k++) begin sq.push_back(st); sf.push_back(1'b0); end
            sq.push_back(ST_ERR); sf.push_back(1'b0);
            term = 1'b1;
        end else begin
            for (int k = 0; k < d; k++) begin sq.push_back(st); sf.push_back(1'b0); end
            sq.push_back(st); sf.push_back(1'b1);
        end
    endtask

    task automatic build(input int g, r, dg, dr, input logic is_mem, is_halt);
        bit t;
        sq.delete(); sf.delete();
        push_wait(ST_FETCH, g, t); if (t) return;
        push_wait(ST_IWAIT, r, t); if (t) return;
        sq.push_back(ST_EXEC); sf.push_back(1'b0);
        if (is_halt) begin sq.push_back(ST_HALT); sf.push_back(1'b0); return; end
        if (is_mem) begin
            push_wait(ST_MEM, dg, t); if (t) return;
            push_wait(ST_DWAIT, dr, t); if (t) return;
        end
        sq.push_back(ST_WB); sf.push_back(1'b0);
    endtask

    task automatic run_instr(input logic [31:0] inst, input logic wen, mem, mwen, csr,
                             input int g, r, dg, dr, input int abort_st, output int pc_cycle);
        build(g, r, dg, dr, mem, inst == EBREAK);
        cur_wen = wen; cur_mwen = mwen; cur_csr = csr;
        dec_wen = wen; dec_mem = mem; dec_mem_wen = mwen; dec_csr_wen = csr;
        pc_cycle = 0;
        for (int i = 0; i < sq.size(); i++) begin
            int st;
            bit f;
            st = sq[i];
            f  = sf[i];
            @(negedge clk);
            check($sformatf("cyc%0d_st%0d", i, st), actv(), expv(st));
            if (pc_we) pc_cycle = i + 1;
            if (st == abort_st) begin
                rst_n = 1'b0; m_instret = '0; m_inst_q = '0;
                #1;
                check("reset_in_wait", actv(), expv(ST_IDLE));
                return;
            end
            imem_gnt    = (st == ST_FETCH) ? f : 1'($urandom % 2);
            imem_rvalid = (st == ST_IWAIT) ? f : 1'($urandom % 2);
            imem_rdata  = (st == ST_IWAIT && f) ? inst : $urandom;
            dmem_gnt    = (st == ST_MEM)   ? f : 1'($urandom % 2);
            dmem_rvalid = (st == ST_DWAIT) ? f : 1'($urandom % 2);
            if (st == ST_IWAIT && f) m_inst_q = inst;
            if (st == ST_WB) m_instret++;
        end
    endtask

    task automatic hold_check(input int st, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_%0d", name, i), actv(), expv(st));
            imem_gnt = 1'($urandom % 2); imem_rvalid = 1'($urandom % 2); imem_rdata = $urandom;
            dmem_gnt = 1'($urandom % 2); dmem_rvalid = 1'($urandom % 2);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; m_instret = '0; m_inst_q = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        check("reset", actv(), expv(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_after_release", actv(), expv(ST_IDLE));
    endtask

    initial begin
        int pcc;
        logic [31:0] inst;
        logic wen, mem, mwen, csr;

        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dec_wen = 1'b0; dec_mem = 1'b0; dec_mem_wen = 1'b0; dec_csr_wen = 1'b0;
        cur_wen = 1'b0; cur_mwen = 1'b0; cur_csr = 1'b0;
        m_instret = '0; m_inst_q = '0;

        tbl[0] = '{32'h00100093, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 4};
        tbl[1] = '{32'h0000a103, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 2, 1, 9};
        tbl[2] = '{32'h0020a223, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 6};
        tbl[3] = '{32'h340091f3, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2, 0, 0, 7};
        tbl[4] = '{32'h0000a183, 1'b1, 1'b1, 1'b0, 1'b0, 7, 7, 7, 7, 34};

        do_reset();

        for (int i = 0; i < $size(tbl); i++) begin
            run_instr(tbl[i].inst, tbl[i].wen, tbl[i].mem, tbl[i].mwen, tbl[i].csr,
                      tbl[i].g, tbl[i].r, tbl[i].dg, tbl[i].dr, -1, pcc);
            check($sformatf("latency_%0d", i), 76'(pcc), 76'(tbl[i].exp_cycles));
        end

        for (int i = 0; i < 40; i++) begin
            inst = $urandom | 32'h1000_0000;
            wen  = 1'($urandom % 2);
            mem  = 1'($urandom % 2);
            mwen = mem & 1'($urandom % 2);
            csr  = !mem & 1'($urandom % 2);
            run_instr(inst, wen, mem, mwen, csr,
                      (($urandom % 8) == 0) ? 7 : int'($urandom_range(0, 2)),
                      (($urandom % 8) == 0) ? 7 : int'($urandom_range(0, 2)),
                      (($urandom % 8) == 0) ? 7 : int'($urandom_range(0, 2)),
                      (($urandom % 8) == 0) ? 7 : int'($urandom_range(0, 2)), -1, pcc);
        end

        run_instr(32'h0000a103, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 4, ST_DWAIT, pcc);
        do_reset();
        run_instr(32'h00100093, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, -1, pcc);

        do_reset();
        run_instr(32'h00100093, 1'b1, 1'b0, 1'b0, 1'b0, TO, 0, 0, 0, -1, pcc);
        hold_check(ST_ERR, 10, "err_fetch");

        do_reset();
        run_instr(32'h0000a103, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1, TO + 1, -1, pcc);
        hold_check(ST_ERR, 5, "err_dwait");

        do_reset();
        run_instr(EBREAK, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, -1, pcc);
        hold_check(ST_HALT, 20, "halt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
